// File: rtl/serial_mag_comp.sv
// Serial MSB-first magnitude comparator: one x/y bit pair per accepted cycle, eq/gt/lt published with a one-cycle done pulse.
// Latency WIDTH+1 edges from start (plus stall cycles); bit_valid low stalls indefinitely, start always restarts.
module serial_mag_comp #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_valid,
    input  logic x,
    input  logic y,
    output logic busy,
    output logic done,
    output logic eq,
    output logic gt,
    output logic lt
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          decided;
    logic          gt_i;
    logic          lt_i;
    logic          accept;
    logic          last;
    logic          dec_nxt;
    logic          gt_nxt;
    logic          lt_nxt;

    // start outranks a coincident bit, so a restart never consumes that pair
    assign accept = (state == RUN) && bit_valid && !start;
    assign last   = (cnt == CW'(WIDTH - 1));

    // The first differing pair (MSB first) settles the ordering for good
    always_comb begin
        dec_nxt = decided;
        gt_nxt  = gt_i;
        lt_nxt  = lt_i;
        if (!decided && (x != y)) begin
            dec_nxt = 1'b1;
            gt_nxt  = x & ~y;
            lt_nxt  = ~x & y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                if (start) begin
                    state_nxt = RUN;
                end else if (bit_valid && last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            decided <= 1'b0;
            gt_i    <= 1'b0;
            lt_i    <= 1'b0;
            done    <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
        end else if (start) begin
            cnt     <= '0;
            decided <= 1'b0;
            gt_i    <= 1'b0;
            lt_i    <= 1'b0;
            done    <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
        end else if (accept) begin
            cnt     <= last ? '0 : cnt + 1'b1;
            decided <= dec_nxt;
            gt_i    <= gt_nxt;
            lt_i    <= lt_nxt;
            done    <= last;
            if (last) begin
                eq <= ~dec_nxt;
                gt <= gt_nxt;
                lt <= lt_nxt;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_mag_comp.sv
// Randomized scoreboard bench for serial_mag_comp: driver queues expected {eq,gt,lt} and latency, monitor checks on done.
module tb_serial_mag_comp;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic bit_valid = 1'b0;
    logic x = 1'b0;
    logic y = 1'b0;
    logic busy, done, eq, gt, lt;

    serial_mag_comp #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
        .x(x), .y(y), .busy(busy), .done(done), .eq(eq), .gt(gt), .lt(lt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] res;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         start_edge = 0;
    int         done_cnt = 0;
    int         exp_done = 0;
    logic [2:0] last_res = 3'b000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (start && rst_n) start_edge = cyc;
    end

    // Monitor: latency counts edges from the start edge to the edge that samples done
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_res = 3'b000;
        end else begin
            if (busy) chk("busy_outputs_clear", {28'd0, done, eq, gt, lt}, 32'd0);
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    chk("result_eq_gt_lt", {29'd0, eq, gt, lt}, {29'd0, e.res});
                    chk("latency", cyc + 1 - start_edge, e.lat);
                end
                last_res = {eq, gt, lt};
            end else if (!busy) begin
                chk("result_hold", {29'd0, eq, gt, lt}, {29'd0, last_res});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // x=1,y=0 alongside start: if wrongly accepted it would corrupt the count and result
    task automatic do_start(input logic bv);
        start = 1'b1;
        bit_valid = bv;
        x = 1'b1;
        y = 1'b0;
        step();
        start = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic feed(input logic [W-1:0] xv, input logic [W-1:0] yv, input int nbits,
                        input bit rand_stall, input int stall_pos, input int stall_len);
        int   stalls[W];
        int   total;
        exp_t e;
        total = 0;
        for (int i = 0; i < W; i++) begin
            stalls[i] = rand_stall ? int'($urandom_range(0, 1)) : 0;
            if (i == stall_pos) stalls[i] += stall_len;
            if (i < nbits) total += stalls[i];
        end
        if (nbits == W) begin
            e.res = {xv == yv, xv > yv, xv < yv};
            e.lat = W + 1 + total;
            sb.push_back(e);
            exp_done++;
        end
        for (int i = 0; i < nbits; i++) begin
            for (int s = 0; s < stalls[i]; s++) begin
                bit_valid = 1'b0;
                x = 1'($urandom);
                y = 1'($urandom);
                step();
            end
            bit_valid = 1'b1;
            x = xv[W-1-i];
            y = yv[W-1-i];
            step();
        end
        bit_valid = 1'b0;
    endtask

    initial begin
        logic [W-1:0] rx, ry;
        #1;
        chk("reset_state", {27'd0, busy, done, eq, gt, lt}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Reset mid-run after 3 bits must clear outputs asynchronously
        do_start(1'b0);
        feed(8'h5A, 8'h3C, 3, 1'b0, -1, 0);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_mid_run", {27'd0, busy, done, eq, gt, lt}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        do_start(1'b0);
        feed(8'hC3, 8'h3C, W, 1'b0, -1, 0);

        do_start(1'b0);
        feed(8'hA5, 8'hA5, W, 1'b0, -1, 0);
        do_start(1'b0);
        feed(8'h80, 8'h7F, W, 1'b0, -1, 0);
        do_start(1'b0);
        feed(8'h12, 8'h13, W, 1'b0, 4, 3);

        // Abort after 4 bits, then a full stream
        do_start(1'b0);
        feed(8'hFF, 8'h00, 4, 1'b0, -1, 0);
        do_start(1'b0);
        feed(8'h00, 8'hFF, W, 1'b0, -1, 0);

        // start coincident with the completing pair: restart wins, no done
        do_start(1'b0);
        feed(8'h55, 8'hAA, W - 1, 1'b0, -1, 0);
        start = 1'b1;
        bit_valid = 1'b1;
        x = 1'b1;
        y = 1'b0;
        step();
        start = 1'b0;
        bit_valid = 1'b0;
        feed(8'h33, 8'h33, W, 1'b0, -1, 0);

        // bit_valid while idle, then start with bit_valid high
        step();
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1;
            x = 1'($urandom);
            y = 1'($urandom);
            step();
        end
        bit_valid = 1'b0;
        do_start(1'b1);
        feed(8'h6E, 8'h6E, W, 1'b0, -1, 0);

        for (int n = 0; n < 24; n++) begin
            rx = W'($urandom);
            ry = ($urandom_range(0, 3) == 0) ? rx : W'($urandom);
            do_start(1'b0);
            feed(rx, ry, W, 1'b1, -1, 0);
            if ($urandom_range(0, 2) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) step();
            end
        end

        for (int t = 0; t < 100 && sb.size() != 0; t++) step();
        step();
        chk("scoreboard_drained", sb.size(), 0);
        chk("done_pulse_count", done_cnt, exp_done);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
